pb_debounce: RTL
================

// Module: pb_debounce
//
// PURPOSE
// - Debounces WIDTH synchronized, mechanically bouncing inputs (push buttons, DIP switches).
// - Sits directly downstream of the cdc_async_bit_no_rst synchronizers and directly upstream
//   of the LED/user logic.
// - Per channel it produces a clean level plus one-cycle press, release and long-press pulses.
//
// PARAMETERS
// - WIDTH            3         number of independent channels
// - ACTIVE_LOW       1         1: d low = pressed/ON (board pull-ups); 0: d high = pressed
// - DEBOUNCE_CYCLES  120000    consecutive stable samples needed to accept a change (10 ms at 12 MHz)
// - LONG_CYCLES      12000000  cycles q must stay pressed before long_press fires (1 s at 12 MHz)
//
// PORTS
// - clk         in   1      single clock (clk_12mhz at top level)
// - rst         in   1      synchronous, active-high reset
// - d           in   WIDTH  synchronized raw inputs; no further synchronization inside
// - q           out  WIDTH  debounced level; 1 = pressed/ON regardless of ACTIVE_LOW
// - press       out  WIDTH  1-cycle pulse on the cycle q rises
// - release_p   out  WIDTH  1-cycle pulse on the cycle q falls
// - long_press  out  WIDTH  1-cycle pulse, once per press, after LONG_CYCLES held
//
// BEHAVIOUR
// - Input mapping: a = ACTIVE_LOW ? ~d : d. All logic below uses a.
// - Elaboration checks (fatal on failure):
//   - DEBOUNCE_CYCLES >= 2
//   - LONG_CYCLES > DEBOUNCE_CYCLES
// - Reset (rst=1 at a clk edge), every channel:
//   - state=REL, counters=0, q=0, press=0, release_p=0, long_press=0.
//   - Reset overrides everything; reset mid-debounce or mid-hold discards progress and emits no pulse.
// - Per-channel FSM states: REL, WAIT_PRS, PRS, WAIT_REL. Debounce counter dcnt is sized
//   $clog2(DEBOUNCE_CYCLES+1).
//   - REL: a=1 -> WAIT_PRS, dcnt=1; a=0 -> stay.
//   - WAIT_PRS, a=0: back to REL, dcnt=0, no pulse.
//   - WAIT_PRS, a=1 and dcnt<DEBOUNCE_CYCLES-1: dcnt++.
//   - WAIT_PRS, a=1 and dcnt==DEBOUNCE_CYCLES-1: -> PRS, dcnt=0, q<=1, press<=1 for one cycle.
//   - PRS, WAIT_REL: mirror images with a inverted; the accepting edge sets q<=0 and release_p<=1.
// - Latency:
//   - q and the press/release pulse register on the edge at which a has been sampled at the new
//     level on DEBOUNCE_CYCLES consecutive edges.
//   - Any single opposite sample restarts the count.
// - Long press: hold counter hcnt is sized $clog2(LONG_CYCLES+1).
//   - hcnt=0 while q=0.
//   - While q=1 (PRS and WAIT_REL), hcnt increments, saturating at LONG_CYCLES.
//   - long_press<=1 for exactly one cycle on the edge where hcnt goes LONG_CYCLES-1 -> LONG_CYCLES.
//     It never repeats until q has fallen and risen again.
//   - Release accepted before then: no long_press.
// - Boundaries:
//   - Input asserted at reset release: normal press after DEBOUNCE_CYCLES edges.
//   - Bounce in WAIT_REL does not reset hcnt.
//   - press and release_p are never both 1 in one cycle.
// - Channels are fully independent; simultaneous events on different bits are all reported in
//   the same cycle.
// - No combinational path from d to any output; all outputs are registered.
//
// STRUCTURE
// - Package debounce_pkg:
//   - typedef enum logic [1:0] {REL, WAIT_PRS, PRS, WAIT_REL} db_state_t
// - Sub-module debounce_channel: one channel (FSM, dcnt, hcnt, output regs), same parameters
//   minus WIDTH.
// - pb_debounce: ACTIVE_LOW inversion plus a generate loop of WIDTH debounce_channel instances.
//
// TESTING (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1, WIDTH=3)
// - Reset: hold rst 3 cycles with d=3'b111 -> q=0 and all pulses 0 during and after reset.
// - Clean press:
//   - d[0]=0 from edge N -> q[0]=1 and press[0]=1 at edge N+3; press[0]=0 at N+4.
//   - d[0]=1 later -> release_p[0]=1 after 4 edges.
// - Bounce: d[1] pattern 0,0,0,1,0,0,0,0 -> q[1] rises only after the final 4 lows;
//   exactly one press[1] pulse.
// - Long press: hold d[2]=0 for 40 cycles -> press[2] once; long_press[2] once, 20 edges after
//   press[2]; then release_p[2] once.
// - Short press: d[2] low 10 cycles -> press and release_p pulses, no long_press.
// - Reset mid-debounce: rst after 2 low samples -> no press pulse; press fires 4 edges after
//   reset release if d stays low.

Source files
------------

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared types for the push-button debouncer
package debounce_pkg;
    typedef enum logic [1:0] {REL, WAIT_PRS, PRS, WAIT_REL} db_state_t;
endpackage

// File: rtl/debounce_channel.sv
// debounce_channel: one debounced channel with press, release and long-press pulses
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic clk,
    input  logic rst,
    input  logic a,
    output logic q,
    output logic press,
    output logic release_p,
    output logic long_press
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);
    localparam logic [HW-1:0] H_PRE  = HW'(LONG_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2) begin : g_chk_db
        $fatal(1, "DEBOUNCE_CYCLES must be >= 2");
    end
    if (LONG_CYCLES <= DEBOUNCE_CYCLES) begin : g_chk_long
        $fatal(1, "LONG_CYCLES must exceed DEBOUNCE_CYCLES");
    end

    db_state_t       state;
    logic [DW-1:0]   dcnt;
    logic [HW-1:0]   hcnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= REL;
            dcnt       <= '0;
            hcnt       <= '0;
            q          <= 1'b0;
            press      <= 1'b0;
            release_p  <= 1'b0;
            long_press <= 1'b0;
        end else begin
            press      <= 1'b0;
            release_p  <= 1'b0;
            long_press <= 1'b0;
            case (state)
                REL: begin
                    if (a) begin
                        state <= WAIT_PRS;
                        dcnt  <= DW'(1);
                    end
                end
                WAIT_PRS: begin
                    if (!a) begin
                        state <= REL;
                        dcnt  <= '0;
                    end else if (dcnt == D_LAST) begin
                        state <= PRS;
                        dcnt  <= '0;
                        q     <= 1'b1;
                        press <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
                PRS: begin
                    if (!a) begin
                        state <= WAIT_REL;
                        dcnt  <= DW'(1);
                    end
                end
                WAIT_REL: begin
                    if (a) begin
                        state <= PRS;
                        dcnt  <= '0;
                    end else if (dcnt == D_LAST) begin
                        state     <= REL;
                        dcnt      <= '0;
                        q         <= 1'b0;
                        release_p <= 1'b1;
                    end else begin
                        dcnt <= dcnt + DW'(1);
                    end
                end
            endcase
            // hold time follows the registered level, so bounces during release keep counting
            if (!q) begin
                hcnt <= '0;
            end else if (hcnt != H_MAX) begin
                hcnt       <= hcnt + HW'(1);
                long_press <= (hcnt == H_PRE);
            end
        end
    end
endmodule

// File: rtl/pb_debounce.sv
// pb_debounce: polarity mapping plus WIDTH independent debounce channels
module pb_debounce #(
    parameter int WIDTH           = 3,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter int LONG_CYCLES     = 12000000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] press,
    output logic [WIDTH-1:0] release_p,
    output logic [WIDTH-1:0] long_press
);
    logic [WIDTH-1:0] a;

    assign a = ACTIVE_LOW ? ~d : d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .a         (a[i]),
            .q         (q[i]),
            .press     (press[i]),
            .release_p (release_p[i]),
            .long_press(long_press[i])
        );
    end
endmodule
